// File: rtl/counter_pkg.sv
// Shared encodings for the multi-mode counter: count types and end-of-count policies.
package counter_pkg;

  localparam logic [1:0] CT_BIN     = 2'd0;
  localparam logic [1:0] CT_GRAY    = 2'd1;
  localparam logic [1:0] CT_RING    = 2'd2;
  localparam logic [1:0] CT_JOHN    = 2'd3;

  // Code 3 is reserved and behaves as wrap since only stop/bounce are decoded.
  localparam logic [1:0] EOC_WRAP   = 2'd0;
  localparam logic [1:0] EOC_STOP   = 2'd1;
  localparam logic [1:0] EOC_BOUNCE = 2'd2;

endpackage

// File: rtl/counter_mm_gray_codec.sv
// Combinational gray codec: independent bin->gray encode and gray->bin decode paths.
module gray_codec #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic [COUNT_WIDTH-1:0] i_bin,
  input  logic [COUNT_WIDTH-1:0] i_gray,
  output logic [COUNT_WIDTH-1:0] o_gray,
  output logic [COUNT_WIDTH-1:0] o_bin
);

  assign o_gray = i_bin ^ (i_bin >> 1);

  // Each binary bit is the XOR of all gray bits at or above it; no ripple chain.
  for (genvar gi = 0; gi < COUNT_WIDTH; gi++) begin : g_dec
    assign o_bin[gi] = ^(i_gray >> gi);
  end

endmodule

// File: rtl/counter_mm.sv
// Multi-mode counter (binary/gray/ring/johnson) with limit, wrap/stop/bounce policy,
// registered terminal-count pulse and done flag.
module counter_mm
  import counter_pkg::*;
#(
  parameter int         COUNT_WIDTH = 8,
  parameter logic [1:0] TYPE_RESET  = 2'd0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_,
  input  logic [COUNT_WIDTH-1:0] load_val,
  input  logic [COUNT_WIDTH-1:0] limit,
  input  logic [1:0]             count_type,
  input  logic [1:0]             eoc_mode,
  input  logic                   count_dir,
  input  logic                   count_enable_,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   tc,
  output logic                   done,
  output logic                   dir_eff
);

  localparam logic [COUNT_WIDTH-1:0] ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [COUNT_WIDTH-1:0] r_count, r_limit, r_start;
  logic [1:0]             r_type, r_eoc;
  logic                   r_tc, r_done, r_flip;

  logic [COUNT_WIDTH-1:0] w_cur_dec, w_cur_bin, w_bin_next, w_next_gray;
  logic [COUNT_WIDTH-1:0] w_load_dec, w_load_bin, w_limit_gray, w_load_count;
  logic [COUNT_WIDTH-1:0] w_rot, w_step_val;
  logic                   w_dir, w_is_bg, w_bg_bound, w_rot_bound, w_bound, w_step;
  logic                   w_ins_up, w_ins_dn;

  assign w_dir   = count_dir ^ r_flip;
  assign w_is_bg = (r_type == CT_BIN) || (r_type == CT_GRAY);

  // Count path: decode the current value, encode the stepped value.
  gray_codec #(.COUNT_WIDTH(COUNT_WIDTH)) u_count_codec (
    .i_bin  (w_bin_next),
    .i_gray (r_count),
    .o_gray (w_next_gray),
    .o_bin  (w_cur_dec)
  );

  // Load path: decode load_val for the clamp test, encode limit for a clamped gray load.
  gray_codec #(.COUNT_WIDTH(COUNT_WIDTH)) u_load_codec (
    .i_bin  (limit),
    .i_gray (load_val),
    .o_gray (w_limit_gray),
    .o_bin  (w_load_dec)
  );

  assign w_cur_bin  = (r_type == CT_GRAY) ? w_cur_dec : r_count;
  assign w_load_bin = (count_type == CT_GRAY) ? w_load_dec : load_val;

  always_comb begin
    w_load_count = load_val;
    if ((count_type == CT_BIN || count_type == CT_GRAY) && (w_load_bin > limit)) begin
      w_load_count = (count_type == CT_GRAY) ? w_limit_gray : limit;
    end
  end

  assign w_bg_bound = w_dir ? (w_cur_bin == r_limit) : (w_cur_bin == '0);

  always_comb begin
    w_bin_next = w_dir ? (w_cur_bin + ONE) : (w_cur_bin - ONE);
    if (w_bg_bound) begin
      if (r_eoc == EOC_BOUNCE) begin
        // Reversal steps one unit back the other way; a zero limit has nowhere to go.
        if (r_limit == '0) w_bin_next = '0;
        else               w_bin_next = w_dir ? (r_limit - ONE) : ONE;
      end else begin
        w_bin_next = w_dir ? '0 : r_limit;
      end
    end
  end

  assign w_ins_up = (r_type == CT_JOHN) ? ~r_count[0]             : r_count[0];
  assign w_ins_dn = (r_type == CT_JOHN) ? ~r_count[COUNT_WIDTH-1] : r_count[COUNT_WIDTH-1];
  assign w_rot    = w_dir ? {w_ins_up, r_count[COUNT_WIDTH-1:1]}
                          : {r_count[COUNT_WIDTH-2:0], w_ins_dn};
  assign w_rot_bound = (w_rot == r_start);

  assign w_bound    = w_is_bg ? w_bg_bound : w_rot_bound;
  assign w_step     = ~count_enable_ & ~r_done;
  assign w_step_val = !w_is_bg ? w_rot : ((r_type == CT_GRAY) ? w_next_gray : w_bin_next);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
      r_flip  <= 1'b0;
      r_type  <= TYPE_RESET;
      r_eoc   <= EOC_WRAP;
      r_limit <= '1;
      r_start <= '0;
    end else if (!load_) begin
      r_count <= w_load_count;
      r_type  <= count_type;
      r_eoc   <= eoc_mode;
      r_limit <= limit;
      r_start <= load_val;
      r_flip  <= 1'b0;
      r_done  <= 1'b0;
      r_tc    <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (w_step) begin
        r_tc <= w_bound;
        // Binary/gray stop refuses the boundary step; ring/johnson take it first.
        if (!(w_bound && w_is_bg && r_eoc == EOC_STOP)) r_count <= w_step_val;
        if (w_bound && r_eoc == EOC_STOP)   r_done <= 1'b1;
        if (w_bound && r_eoc == EOC_BOUNCE) r_flip <= ~r_flip;
      end
    end
  end

  assign count   = r_count;
  assign tc      = r_tc;
  assign done    = r_done;
  assign dir_eff = w_dir;

endmodule

// File: tb/tb_counter_mm.sv
// Self-checking bench for counter_mm: directed vector table, corner sequences and
// randomized traffic against an arithmetic reference model.
module tb_counter_mm;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset, load_, count_dir, count_enable_;
  logic [W-1:0] load_val, limit;
  logic [1:0]   count_type, eoc_mode;
  logic [W-1:0] count;
  logic         tc, done, dir_eff;

  int n_checks = 0;
  int n_errors = 0;

  counter_mm #(.COUNT_WIDTH(W), .TYPE_RESET(2'd0)) dut (
    .clk           (clk),
    .reset         (reset),
    .load_         (load_),
    .load_val      (load_val),
    .limit         (limit),
    .count_type    (count_type),
    .eoc_mode      (eoc_mode),
    .count_dir     (count_dir),
    .count_enable_ (count_enable_),
    .count         (count),
    .tc            (tc),
    .done          (done),
    .dir_eff       (dir_eff)
  );

  always #5 clk = ~clk;

  // Reference model state: count kept in its native encoding.
  int unsigned m_count, m_limit, m_start;
  int unsigned m_type, m_eoc;
  bit          m_flip, m_done, m_tc;

  function automatic int unsigned g2b(input int unsigned g);
    int unsigned b = 0;
    for (int s = 0; s < W; s++) b ^= (g >> s);
    return b & MAXV;
  endfunction

  function automatic int unsigned b2g(input int unsigned b);
    return (b ^ (b >> 1)) & MAXV;
  endfunction

  task automatic model_clock(input bit rst, input bit ld_n, input int unsigned lv,
                             input int unsigned lim, input int unsigned ct,
                             input int unsigned eoc, input bit dir, input bit en_n);
    int unsigned v, nxt, ins;
    bit d, at_end;
    if (rst) begin
      m_count = 0; m_tc = 0; m_done = 0; m_flip = 0;
      m_type = 0; m_eoc = 0; m_limit = MAXV; m_start = 0;
    end else if (!ld_n) begin
      m_type = ct; m_eoc = (eoc == 3) ? 0 : eoc; m_limit = lim; m_start = lv;
      m_flip = 0; m_done = 0; m_tc = 0;
      if (ct >= 2) m_count = lv;
      else begin
        v = (ct == 1) ? g2b(lv) : lv;
        if (v > lim) v = lim;
        m_count = (ct == 1) ? b2g(v) : v;
      end
    end else begin
      m_tc = 0;
      if (!en_n && !m_done) begin
        d = dir ^ m_flip;
        if (m_type < 2) begin
          v = (m_type == 1) ? g2b(m_count) : m_count;
          at_end = d ? (v == m_limit) : (v == 0);
          if (!at_end) v = d ? v + 1 : v - 1;
          else begin
            m_tc = 1;
            if (m_eoc == 1) m_done = 1;
            else if (m_eoc == 2) begin
              m_flip = ~m_flip;
              if (m_limit == 0) v = 0;
              else v = d ? v - 1 : v + 1;
            end else v = d ? 0 : m_limit;
          end
          m_count = (m_type == 1) ? b2g(v & MAXV) : (v & MAXV);
        end else begin
          if (d) begin
            ins = (m_count & 1) ^ ((m_type == 3) ? 1 : 0);
            nxt = (m_count >> 1) | (ins << (W - 1));
          end else begin
            ins = ((m_count >> (W - 1)) & 1) ^ ((m_type == 3) ? 1 : 0);
            nxt = ((m_count << 1) & MAXV) | ins;
          end
          m_count = nxt;
          if (nxt == m_start) begin
            m_tc = 1;
            if (m_eoc == 1) m_done = 1;
            else if (m_eoc == 2) m_flip = ~m_flip;
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input bit rst, input bit ld_n, input logic [W-1:0] lv,
                       input logic [W-1:0] lim, input logic [1:0] ct, input logic [1:0] eoc,
                       input bit dir, input bit en_n, input string tag);
    reset = rst; load_ = ld_n; load_val = lv; limit = lim;
    count_type = ct; eoc_mode = eoc; count_dir = dir; count_enable_ = en_n;
    model_clock(rst, ld_n, lv, lim, ct, eoc, dir, en_n);
    @(posedge clk); #1;
    chk({tag, "_count"}, 32'(count), m_count);
    chk({tag, "_tc"}, 32'(tc), 32'(m_tc));
    chk({tag, "_done"}, 32'(done), 32'(m_done));
    chk({tag, "_dir_eff"}, 32'(dir_eff), 32'(dir ^ m_flip));
    $display("%s rst=%0b ld_n=%0b en_n=%0b dir=%0b -> count=%h tc=%0b done=%0b dir_eff=%0b",
             tag, rst, ld_n, en_n, dir, count, tc, done, dir_eff);
  endtask

  typedef struct {
    bit         ld_n;
    logic [3:0] lv;
    logic [3:0] lim;
    logic [1:0] ct;
    logic [1:0] eoc;
    bit         dir;
    logic [3:0] e_count;
    bit         e_tc;
    bit         e_done;
    bit         e_dir;
  } vec_t;

  vec_t vecs[$];

  task automatic ld(input logic [3:0] lv, input logic [3:0] lim, input logic [1:0] ct,
                    input logic [1:0] eoc, input bit dir, input logic [3:0] ec);
    vec_t v;
    v = '{1'b0, lv, lim, ct, eoc, dir, ec, 1'b0, 1'b0, dir};
    vecs.push_back(v);
  endtask

  task automatic st(input bit dir, input logic [3:0] ec, input bit etc,
                    input bit edone, input bit edir);
    vec_t v;
    v = '{1'b1, 4'h0, 4'h0, 2'd0, 2'd0, dir, ec, etc, edone, edir};
    vecs.push_back(v);
  endtask

  bit rdir;

  initial begin
    reset = 1'b1; load_ = 1'b1; load_val = '0; limit = '0;
    count_type = 2'd0; eoc_mode = 2'd0; count_dir = 1'b1; count_enable_ = 1'b1;

    apply(1, 1, 0, 0, 0, 0, 1, 1, "reset");
    chk("reset_count_zero", 32'(count), 0);

    // Binary up, limit 5, wrap
    ld(0, 5, 0, 0, 1, 0);
    st(1, 1, 0, 0, 1); st(1, 2, 0, 0, 1); st(1, 3, 0, 0, 1); st(1, 4, 0, 0, 1);
    st(1, 5, 0, 0, 1); st(1, 0, 1, 0, 1); st(1, 1, 0, 0, 1);
    // Binary down, limit 5, stop
    ld(2, 5, 0, 1, 0, 2);
    st(0, 1, 0, 0, 0); st(0, 0, 0, 0, 0); st(0, 0, 1, 1, 0);
    st(0, 0, 0, 1, 0); st(0, 0, 0, 1, 0);
    ld(2, 5, 0, 1, 0, 2);
    // Gray up, limit 3, bounce
    ld(0, 3, 1, 2, 1, 0);
    st(1, 1, 0, 0, 1); st(1, 3, 0, 0, 1); st(1, 2, 0, 0, 1); st(1, 3, 1, 0, 0);
    st(1, 1, 0, 0, 0); st(1, 0, 0, 0, 0); st(1, 1, 1, 0, 1);
    // Ring up, wrap, then clamped binary load
    ld(4'b0001, 0, 2, 0, 1, 4'b0001);
    st(1, 4'b1000, 0, 0, 1); st(1, 4'b0100, 0, 0, 1); st(1, 4'b0010, 0, 0, 1);
    st(1, 4'b0001, 1, 0, 1);
    ld(4'b1001, 5, 0, 0, 1, 4'b0101);
    // Johnson up, stop
    ld(0, 0, 3, 1, 1, 0);
    st(1, 4'h8, 0, 0, 1); st(1, 4'hC, 0, 0, 1); st(1, 4'hE, 0, 0, 1); st(1, 4'hF, 0, 0, 1);
    st(1, 4'h7, 0, 0, 1); st(1, 4'h3, 0, 0, 1); st(1, 4'h1, 0, 0, 1);
    st(1, 4'h0, 1, 1, 1); st(1, 4'h0, 0, 1, 1);

    foreach (vecs[i]) begin
      apply(0, vecs[i].ld_n, vecs[i].lv, vecs[i].lim, vecs[i].ct, vecs[i].eoc,
            vecs[i].dir, 1'b0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_exp_count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("vec%0d_exp_tc", i), 32'(tc), 32'(vecs[i].e_tc));
      chk($sformatf("vec%0d_exp_done", i), 32'(done), 32'(vecs[i].e_done));
      chk($sformatf("vec%0d_exp_dir", i), 32'(dir_eff), 32'(vecs[i].e_dir));
    end

    // Limit 0, wrap: load 5 clamps to 0, tc on every enabled cycle
    apply(0, 0, 5, 0, 0, 0, 1, 1, "deg_wrap_ld");
    chk("deg_wrap_clamp", 32'(count), 0);
    for (int k = 0; k < 3; k++) begin
      apply(0, 1, 0, 0, 0, 0, 1, 0, "deg_wrap");
      chk("deg_wrap_tc_each", 32'(tc), 1);
    end
    // Limit 0, stop: done on first enable
    apply(0, 0, 0, 0, 0, 1, 1, 1, "deg_stop_ld");
    apply(0, 1, 0, 0, 0, 0, 1, 0, "deg_stop");
    chk("deg_stop_done", 32'(done), 1);
    chk("deg_stop_tc", 32'(tc), 1);
    apply(0, 1, 0, 0, 0, 0, 1, 0, "deg_stop2");
    chk("deg_stop_tc_once", 32'(tc), 0);
    // Limit 0, gray bounce: flip toggles every enabled cycle
    apply(0, 0, 0, 0, 1, 2, 1, 1, "deg_bnc_ld");
    apply(0, 1, 0, 0, 0, 0, 1, 0, "deg_bnc1");
    chk("deg_bnc1_dir", 32'(dir_eff), 0);
    chk("deg_bnc1_tc", 32'(tc), 1);
    apply(0, 1, 0, 0, 0, 0, 1, 0, "deg_bnc2");
    chk("deg_bnc2_dir", 32'(dir_eff), 1);
    // All-zero ring start: holds 0 with tc every step
    apply(0, 0, 0, 0, 2, 0, 1, 1, "ring0_ld");
    for (int k = 0; k < 2; k++) begin
      apply(0, 1, 0, 0, 0, 0, 1, 0, "ring0");
      chk("ring0_tc", 32'(tc), 1);
    end

    // Reset with simultaneous load mid-count restores binary/wrap/all-ones limit
    apply(0, 0, 0, 3, 1, 1, 1, 1, "rstmid_ld");
    apply(0, 1, 0, 0, 0, 0, 1, 0, "rstmid_s1");
    apply(0, 1, 0, 0, 0, 0, 1, 0, "rstmid_s2");
    apply(1, 0, 7, 3, 1, 1, 1, 0, "rstmid_rst");
    chk("rstmid_count", 32'(count), 0);
    chk("rstmid_tc", 32'(tc), 0);
    chk("rstmid_done", 32'(done), 0);
    for (int k = 1; k <= 16; k++) begin
      apply(0, 1, 0, 0, 0, 0, 1, 0, "rstmid_run");
      if (k == 5) chk("rstmid_binary5", 32'(count), 5);
    end
    chk("rstmid_wrap_count", 32'(count), 0);
    chk("rstmid_wrap_tc", 32'(tc), 1);

    // Randomized traffic against the model
    rdir = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(7) == 0) rdir = ~rdir;
      apply(($urandom_range(99) == 0), !($urandom_range(11) == 0), 4'($urandom), 4'($urandom),
            2'($urandom), 2'($urandom), rdir, ($urandom_range(3) == 0), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
